// File: rtl/rv32v_div_sequencer.sv
// Element sequencer in front of the RV32V lane divider: walks vl elements,
// skips masked-off ones, issues each active pair and writes back its result.
module rv32v_div_sequencer #(
  parameter int VLMAX  = 32,
  parameter int DATA_W = 32,
  localparam int IW    = $clog2(VLMAX),
  localparam int VLW   = IW + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VLW-1:0]    req_vl,
  input  logic              req_unsigned,
  input  logic              req_rem,
  input  logic              req_vm,
  input  logic [VLMAX-1:0]  req_mask,
  output logic [IW-1:0]     elem_idx,
  input  logic [DATA_W-1:0] vs1_elem,
  input  logic [DATA_W-1:0] vs2_elem,
  output logic              div_en,
  output logic [DATA_W-1:0] div_vs1,
  output logic [DATA_W-1:0] div_vs2,
  output logic              div_unsigned,
  output logic              div_rem,
  input  logic              div_busy,
  input  logic [DATA_W-1:0] div_res,
  output logic              wb_valid,
  output logic [IW-1:0]     wb_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [VLW-1:0]   vl_r;
  logic [VLMAX-1:0] mask_r;
  logic             last_elem;

  // idx never passes vl-1, so vl=VLMAX ends at VLMAX-1 without wrapping
  assign last_elem = ({1'b0, idx} == (vl_r - VLW'(1)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= S_IDLE;
      idx          <= '0;
      vl_r         <= '0;
      mask_r       <= '0;
      div_vs1      <= '0;
      div_vs2      <= '0;
      div_unsigned <= 1'b0;
      div_rem      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            vl_r         <= req_vl;
            div_unsigned <= req_unsigned;
            div_rem      <= req_rem;
            mask_r       <= req_vm ? '1 : req_mask;
            idx          <= '0;
            state        <= (req_vl == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (mask_r[idx]) begin
            div_vs1 <= vs1_elem;
            div_vs2 <= vs2_elem;
            state   <= S_ISSUE;
          end else if (last_elem) begin
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // divider finish cycle: result is written back combinationally now
          if (!div_busy) begin
            if (last_elem) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_LOAD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign div_en    = (state == S_ISSUE);
  assign elem_idx  = idx;
  assign wb_valid  = (state == S_WAIT) && !div_busy;
  assign wb_idx    = wb_valid ? idx : '0;
  assign wb_data   = wb_valid ? div_res : '0;

endmodule

// File: tb/tb_rv32v_div_sequencer.sv
// Bench for rv32v_div_sequencer: behavioural divider with random latency,
// reference RISC-V divide rules, and per-request writeback/timing checks.
module tb_rv32v_div_sequencer;
  localparam int VLMAX = 32;
  localparam int IW    = 5;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              req_valid, req_ready;
  logic [IW:0]       req_vl;
  logic              req_unsigned, req_rem, req_vm;
  logic [VLMAX-1:0]  req_mask;
  logic [IW-1:0]     elem_idx;
  logic [31:0]       vs1_elem, vs2_elem;
  logic              div_en, div_unsigned, div_rem, div_busy;
  logic [31:0]       div_vs1, div_vs2, div_res;
  logic              wb_valid, done, busy;
  logic [IW-1:0]     wb_idx;
  logic [31:0]       wb_data;

  logic [31:0] op1 [VLMAX];
  logic [31:0] op2 [VLMAX];

  int nchk = 0, nerr = 0;

  rv32v_div_sequencer dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_vl(req_vl), .req_unsigned(req_unsigned), .req_rem(req_rem),
    .req_vm(req_vm), .req_mask(req_mask), .elem_idx(elem_idx),
    .vs1_elem(vs1_elem), .vs2_elem(vs2_elem), .div_en(div_en),
    .div_vs1(div_vs1), .div_vs2(div_vs2), .div_unsigned(div_unsigned),
    .div_rem(div_rem), .div_busy(div_busy), .div_res(div_res),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign vs1_elem = op1[elem_idx];
  assign vs2_elem = op2[elem_idx];

  // RISC-V divide semantics: dividend vs2, divisor vs1
  function automatic logic [31:0] ref_div(logic [31:0] a, logic [31:0] b, logic uns, logic rem);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (uns) return rem ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  // Divider stub: busy from start cycle, low in finish cycle D cycles later
  logic        dbusy;
  logic [31:0] dres, dpend;
  int          dcnt, dlat;
  int          dq[$];
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dbusy <= 1'b0; dcnt <= 0; dres <= '0; dpend <= '0;
    end else if (div_en) begin
      dlat = $urandom_range(2, 5);
      dq.push_back(dlat);
      dbusy <= 1'b1;
      dcnt  <= dlat - 1;
      dpend <= ref_div(div_vs2, div_vs1, div_unsigned, div_rem);
    end else if (dbusy) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        dbusy <= 1'b0;
        dres  <= dpend;
      end
    end
  end
  assign div_busy = dbusy;
  assign div_res  = dres;

  int ncyc = 0, en_cnt = 0, en_overlap = 0;
  int acc_q[$], done_q[$], wbi_q[$];
  logic [31:0] wbd_q[$];
  always @(negedge CLK) begin
    ncyc++;
    if (req_valid && req_ready) acc_q.push_back(ncyc);
    if (wb_valid) begin wbi_q.push_back(int'(wb_idx)); wbd_q.push_back(wb_data); end
    if (div_en) en_cnt++;
    if (div_en && dbusy) en_overlap++;
    if (done) done_q.push_back(ncyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); done_q.delete(); wbi_q.delete(); wbd_q.delete(); dq.delete();
    en_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_div_en"}, div_en, 0);
    chk({p, "_wb_valid"}, wb_valid, 0);
    chk({p, "_elem_idx"}, elem_idx, 0);
    chk({p, "_wb_idx"}, wb_idx, 0);
    chk({p, "_wb_data"}, wb_data, 0);
    chk({p, "_div_vs1"}, div_vs1, 0);
    chk({p, "_div_vs2"}, div_vs2, 0);
    chk({p, "_div_flags"}, {div_unsigned, div_rem}, 0);
  endtask

  task automatic run_req(input int vl, input logic uns, input logic rem,
                         input logic vm, input logic [31:0] mask);
    int nact, sum, k;
    logic [31:0] m;
    clear_logs();
    m = vm ? 32'hFFFF_FFFF : mask;
    req_vl = 6'(vl); req_unsigned = uns; req_rem = rem; req_vm = vm; req_mask = mask;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 3000 && done_q.size() == 0; t++) step();
    step();
    chk("accept_count", acc_q.size(), 1);
    chk("done_count", done_q.size(), 1);
    nact = 0; sum = 0; k = 0;
    for (int i = 0; i < vl; i++) begin
      if (m[i]) begin
        if (nact < wbi_q.size()) begin
          chk("wb_idx", wbi_q[nact], i);
          chk("wb_data", wbd_q[nact], ref_div(op2[i], op1[i], uns, rem));
        end
        sum += 2 + ((k < dq.size()) ? dq[k] : 0);
        k++; nact++;
      end else begin
        sum += 1;
      end
    end
    chk("wb_count", wbi_q.size(), nact);
    chk("div_en_count", en_cnt, nact);
    if (acc_q.size() > 0 && done_q.size() > 0)
      chk("done_latency", done_q[0] - acc_q[0], 1 + sum);
    chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_vl = '0; req_unsigned = 1'b0;
    req_rem = 1'b0; req_vm = 1'b1; req_mask = '0;
    for (int i = 0; i < VLMAX; i++) begin op1[i] = '0; op2[i] = '0; end
    #12;
    chk_reset_outputs("reset");
    step();
    nRST = 1'b1;
    step();

    // signed quotient, unmasked, including div-by-zero and overflow
    op2[0] = 32'd100;        op1[0] = 32'd7;
    op2[1] = -32'sd9;        op1[1] = 32'd2;
    op2[2] = 32'd5;          op1[2] = 32'd0;
    op2[3] = 32'h8000_0000;  op1[3] = 32'hFFFF_FFFF;
    run_req(4, 1'b0, 1'b0, 1'b1, 32'h0);
    if (wbd_q.size() == 4) begin
      chk("q_100_7", wbd_q[0], 32'd14);
      chk("q_m9_2", wbd_q[1], 32'hFFFF_FFFC);
      chk("q_5_0", wbd_q[2], 32'hFFFF_FFFF);
      chk("q_ovf", wbd_q[3], 32'h8000_0000);
    end

    // unsigned remainder
    op2[0] = 32'd100; op1[0] = 32'd7;
    op2[1] = 32'd7;   op1[1] = 32'd0;
    run_req(2, 1'b1, 1'b1, 1'b1, 32'h0);
    if (wbd_q.size() == 2) begin
      chk("r_100_7", wbd_q[0], 32'd2);
      chk("r_7_0", wbd_q[1], 32'd7);
    end

    // masked: only elements 0 and 2 active
    for (int i = 0; i < 4; i++) begin op2[i] = 32'(50 + i); op1[i] = 32'(i + 3); end
    run_req(4, 1'b0, 1'b0, 1'b0, 32'b0101);
    chk("mask_en_pulses", en_cnt, 2);

    // vl = 0
    run_req(0, 1'b0, 1'b0, 1'b1, 32'h0);

    // reset while waiting on element 1
    clear_logs();
    op2[0] = 32'd9; op1[0] = 32'd3; op2[1] = 32'd8; op1[1] = 32'd2;
    req_vl = 6'd2; req_vm = 1'b1; req_unsigned = 1'b0; req_rem = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 200 && en_cnt < 2; t++) step();
    chk("rst_reached_elem1", en_cnt, 2);
    chk("rst_in_wait_busy", {busy, div_busy}, 2'b11);
    nRST = 1'b0;
    #1;
    chk_reset_outputs("abort");
    step(); step();
    nRST = 1'b1;
    for (int t = 0; t < 6; t++) step();
    chk("abort_no_done", done_q.size(), 0);
    chk("abort_wb_count", wbi_q.size(), 1);
    op2[0] = 32'd77; op1[0] = 32'd11;
    run_req(1, 1'b0, 1'b0, 1'b1, 32'h0);

    // back-to-back: req_valid held through a request
    clear_logs();
    op2[0] = 32'd20; op1[0] = 32'd4;
    req_vl = 6'd1; req_vm = 1'b1; req_valid = 1'b1;
    for (int t = 0; t < 200 && acc_q.size() < 2; t++) step();
    req_valid = 1'b0;
    for (int t = 0; t < 200 && done_q.size() < 2; t++) step();
    chk("b2b_accepts", acc_q.size(), 2);
    chk("b2b_dones", done_q.size(), 2);
    if (acc_q.size() >= 2 && done_q.size() >= 1)
      chk("b2b_accept_after_done", acc_q[1], done_q[0] + 1);

    // randomized requests, one forced to vl = VLMAX
    for (int r = 0; r < 6; r++) begin
      int vl;
      for (int i = 0; i < VLMAX; i++) begin
        op2[i] = $urandom;
        case ($urandom_range(0, 5))
          0: op1[i] = 32'h0;
          1: begin op1[i] = 32'hFFFF_FFFF; op2[i] = 32'h8000_0000; end
          2: op1[i] = $urandom;
          default: op1[i] = $urandom_range(1, 1000);
        endcase
      end
      vl = (r == 0) ? VLMAX : int'($urandom_range(0, VLMAX));
      run_req(vl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom);
    end

    chk("div_en_while_busy", en_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/rv32v_div_sequencer.md
# rv32v_div_sequencer

Element sequencer placed directly upstream of the RV32V lane divider. It accepts one vector divide/remainder request of `vl` elements, reads each element's operand pair, and issues elements one at a time to the lane divider over its enable/busy handshake. It captures each result and presents it on a writeback port with its element index. Masked-off elements are skipped without a divide.

## Interface
Parameters:
- `VLMAX`, 32, maximum elements per request; `IW = $clog2(VLMAX)`, `VLW = IW+1`

Ports:
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request offered
- `req_ready`  out  1  sequencer can accept (IDLE only)
- `req_vl`  in  VLW  element count, 0..VLMAX
- `req_unsigned`  in  1  unsigned divide
- `req_rem`  in  1  1 = remainder, 0 = quotient
- `req_vm`  in  1  1 = unmasked (ignore `req_mask`)
- `req_mask`  in  VLMAX  per-element enable bits (bit i = element i)
- `elem_idx`  out  IW  operand read index
- `vs1_elem`, `vs2_elem`  in  32  operands for `elem_idx`, valid same cycle (combinational read)
- `div_en`  out  1  divider start request
- `div_vs1`, `div_vs2`  out  32  registered operands to divider
- `div_unsigned`, `div_rem`  out  1  registered request flags
- `div_busy`  in  1  divider busy (high in its start cycle, low in its finish cycle)
- `div_res`  in  32  divider result, valid when `div_busy`=0 after issue
- `wb_valid`  out  1  writeback strobe, one cycle per element
- `wb_idx`  out  IW  element index of writeback
- `wb_data`  out  32  result
- `done`  out  1  one-cycle pulse, request complete
- `busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`: latch `vl`, flags, and effective mask (all ones if `req_vm`). Clear idx. Go to DONE if `vl`=0, else LOAD.
- LOAD: `elem_idx`=idx. If the mask bit is 0: no divide, no writeback; if idx=`vl`-1 go to DONE, else idx++ and stay in LOAD. If the mask bit is 1: register `vs1_elem`→`div_vs1` and `vs2_elem`→`div_vs2`, then go to ISSUE.
- ISSUE: `div_en`=1 for exactly this cycle, then go to WAIT.
- WAIT: `div_en`=0, operands and flags held stable. When `div_busy`=0: `wb_valid`=1, `wb_data`=`div_res`, `wb_idx`=idx (combinational that cycle). Then go to DONE if idx=`vl`-1, else idx++ and go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Requests are not accepted outside IDLE; `req_valid` is ignored there.
- Writebacks appear in ascending index order, exactly one per unmasked element.

## Timing
- Reset: state IDLE. `req_ready`=1. `div_en`, `wb_valid`, `done`, `busy`=0. idx, `div_vs1`, `div_vs2`, `wb_idx`, `wb_data`, `div_unsigned`, `div_rem`=0.
- Reset asserted mid-request aborts it immediately with no `done`. The divider shares `nRST` and aborts too.
- Unmasked element with divider latency D (cycles from start cycle to finish cycle): LOAD 1 + ISSUE 1 + D.
- Masked element: 1 cycle (LOAD).
- `vl`=0: accept cycle, then `done` the next cycle.
- `done` appears the cycle after the last element's writeback or skip.
- `div_en` is never high while in WAIT, so the divider is never re-started in its finish cycle.
- `elem_idx` wrap: idx never exceeds `vl`-1. `vl`=VLMAX reaches idx VLMAX-1 with no overflow.

## Test plan
- Unmasked `vl`=4, signed quotient, operands (100,7),(-9,2),(5,0),(0x80000000,-1) → `wb_data` 14, -4, 0xFFFFFFFF, 0x80000000 at `wb_idx` 0..3, then one `done`, 4 `div_en` pulses.
- `req_rem`=1, unsigned, `vl`=2, (100,7),(7,0) → 2, 7.
- `req_vm`=0, mask=0b0101, `vl`=4 → writebacks only at idx 0 and 2; exactly 2 `div_en` pulses.
- `vl`=0 → `done` one cycle after accept; no `div_en`, no `wb_valid`; `req_ready` back to 1.
- `nRST` pulsed during WAIT of element 1 → all outputs at reset values, no `done`. A fresh `vl`=1 request then completes normally.
- Back-to-back: `req_valid` held high through a request → second request accepted only in the cycle after `done`.
